// File: rtl/dcache_pkg.sv
// Shared types and field-width helpers for the direct-mapped write-through data cache.
// Field widths are derived from the line and set counts so that the address split can follow any legal geometry.
package dcache_pkg;

    localparam int DC_DATA_WIDTH     = 32;
    localparam int DC_ADDRESS_WIDTH  = 32;
    localparam int DC_SETS           = 16;
    localparam int DC_WORDS_PER_LINE = 4;

    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int address_width, input int sets, input int words_per_line);
        return address_width - index_w(sets) - offset_w(words_per_line) - 2;
    endfunction

    localparam int OFFSET_W = offset_w(DC_WORDS_PER_LINE);
    localparam int INDEX_W  = index_w(DC_SETS);
    localparam int TAG_W    = tag_w(DC_ADDRESS_WIDTH, DC_SETS, DC_WORDS_PER_LINE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_WR_REQ,
        S_DONE,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
        logic [1:0]          byte_off;
    } addr_split_t;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: async-reset valid bits, combinational read, one word write,
// one line-validate and one single-set invalidate port (invalidate and validate never target the same cycle).
module dcache_array
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_BITS       = 24,
    parameter int IDX_BITS       = index_w(SETS),
    parameter int OFF_BITS       = offset_w(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_BITS-1:0]   i_rd_index,
    input  logic [OFF_BITS-1:0]   i_rd_offset,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [IDX_BITS-1:0]   i_wr_index,
    input  logic [OFF_BITS-1:0]   i_wr_offset,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_val_en,
    input  logic [IDX_BITS-1:0]   i_val_index,
    input  logic [TAG_BITS-1:0]   i_val_tag,
    input  logic                  i_inv_en,
    input  logic [IDX_BITS-1:0]   i_inv_index
);

    logic [SETS-1:0]       r_valid;
    logic [TAG_BITS-1:0]   r_tag  [SETS];
    logic [DATA_WIDTH-1:0] r_data [SETS][WORDS_PER_LINE];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            if (i_inv_en) r_valid[i_inv_index] <= 1'b0;
            if (i_val_en) r_valid[i_val_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset: a line is only ever consulted through its valid bit.
    always_ff @(posedge clk) begin
        if (i_val_en) r_tag[i_val_index] <= i_val_tag;
        if (i_wr_en)  r_data[i_wr_index][i_wr_offset] <= i_wr_data;
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index][i_rd_offset];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-through no-write-allocate data cache with miss/refill FSM; hits return data with no stall.
// Optional DCACHE_STATS_EN adds saturating load hit/miss counters.
module dcache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH     = DC_DATA_WIDTH,
    parameter int ADDRESS_WIDTH  = DC_ADDRESS_WIDTH,
    parameter int SETS           = DC_SETS,
    parameter int WORDS_PER_LINE = DC_WORDS_PER_LINE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     flush,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ready,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int OFF_BITS = offset_w(WORDS_PER_LINE);
    localparam int IDX_BITS = index_w(SETS);
    localparam int TAG_BITS = tag_w(ADDRESS_WIDTH, SETS, WORDS_PER_LINE);

    state_t              r_state, w_state_nxt;
    logic [OFF_BITS-1:0] r_cnt, w_cnt_nxt;
    logic [IDX_BITS-1:0] r_fcnt, w_fcnt_nxt;
    logic                r_pend, w_pend_nxt;

    logic [OFF_BITS-1:0]   w_offset;
    logic [IDX_BITS-1:0]   w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_valid, w_hit, w_load_done, w_unused;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_wr_en, w_val_en, w_inv_en;
    logic [OFF_BITS-1:0]   w_wr_off;
    logic [DATA_WIDTH-1:0] w_wr_dat;
    logic [IDX_BITS-1:0]   w_inv_idx;

    assign w_offset = cpu_addr[OFF_BITS+1:2];
    assign w_index  = cpu_addr[IDX_BITS+OFF_BITS+1:OFF_BITS+2];
    assign w_tag    = cpu_addr[ADDRESS_WIDTH-1:IDX_BITS+OFF_BITS+2];
    assign w_unused = ^cpu_addr[1:0];
    assign w_hit    = w_valid && (w_rd_tag == w_tag);

    dcache_array #(
        .DATA_WIDTH     (DATA_WIDTH),
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_BITS       (TAG_BITS)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_rd_index  (w_index),
        .i_rd_offset (w_offset),
        .o_rd_valid  (w_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_wr_en),
        .i_wr_index  (w_index),
        .i_wr_offset (w_wr_off),
        .i_wr_data   (w_wr_dat),
        .i_val_en    (w_val_en),
        .i_val_index (w_index),
        .i_val_tag   (w_tag),
        .i_inv_en    (w_inv_en),
        .i_inv_index (w_inv_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fcnt  <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fcnt_nxt  = r_fcnt;
        w_pend_nxt  = r_pend | (flush && r_state != S_IDLE);
        cpu_stall   = 1'b0;
        w_load_done = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {w_tag, w_index, r_cnt, 2'b00};
        mem_wdata   = cpu_wdata;
        w_wr_en     = 1'b0;
        w_wr_off    = w_offset;
        w_wr_dat    = cpu_wdata;
        w_val_en    = 1'b0;
        w_inv_en    = 1'b0;
        w_inv_idx   = w_index;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    cpu_stall   = cpu_req;
                    w_fcnt_nxt  = '0;
                    w_state_nxt = S_FLUSH;
                end else if (cpu_req && cpu_we) begin
                    cpu_stall   = 1'b1;
                    w_state_nxt = S_WR_REQ;
                end else if (cpu_req && !w_hit) begin
                    // Drop the victim now so a partial fill can never be seen as a hit.
                    cpu_stall   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_inv_en    = 1'b1;
                    w_state_nxt = S_FILL_REQ;
                end else begin
                    w_load_done = cpu_req;
                end
            end
            S_FILL_REQ: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                if (mem_ready) w_state_nxt = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                cpu_stall = 1'b1;
                if (mem_rvalid) begin
                    w_wr_en   = 1'b1;
                    w_wr_off  = r_cnt;
                    w_wr_dat  = mem_rdata;
                    w_cnt_nxt = r_cnt + OFF_BITS'(1);
                    if (r_cnt == '1) begin
                        w_val_en    = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_FILL_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
                if (mem_ready) begin
                    w_wr_en     = w_hit;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_load_done = cpu_req && !cpu_we;
                if (r_pend || flush) begin
                    w_pend_nxt  = 1'b0;
                    w_fcnt_nxt  = '0;
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                cpu_stall  = 1'b1;
                w_inv_en   = 1'b1;
                w_inv_idx  = r_fcnt;
                w_fcnt_nxt = r_fcnt + IDX_BITS'(1);
                if (r_fcnt == '1) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cpu_rdata = w_load_done ? w_rd_data : '0;

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_load_done && r_state == S_IDLE && r_hit_cnt != '1)  r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_load_done && r_state == S_DONE && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache.sv
// Scoreboarded bench for dcache: drivers push expected CPU completions and memory requests,
// monitors pop and compare on the falling edge.
module tb_dcache;

    logic        clk = 1'b0;
    logic        rst, cpu_req, cpu_we, flush;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dcache dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        int          stalls;
    } cpu_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Backing memory: written words are remembered, others follow a fixed pattern.
    logic [31:0] mem [logic [31:0]];
    int rd_lat = 1;
    int ready_delay = 0;
    int wait_left = 0;
    int pend_cnt = 0;
    int stale_n = 0;
    logic [31:0] pend_data;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    initial begin
        logic acc, acc_we;
        logic [31:0] acc_a, acc_d;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            acc    = rst && mem_req && mem_ready;
            acc_we = mem_we;
            acc_a  = mem_addr;
            acc_d  = mem_wdata;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (acc) begin
                wait_left = ready_delay;
                if (acc_we) mem[acc_a] = acc_d;
                else begin
                    pend_data = mem_rd(acc_a);
                    pend_cnt  = rd_lat;
                end
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                end
            end
            if (stale_n > 0) begin
                stale_n--;
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0BAD0;
            end
            mem_ready = !(mem_req && wait_left > 0);
            if (!mem_ready) wait_left--;
        end
    end

    // CPU-side monitor: counts stall cycles of the held request and checks completion.
    initial begin
        int stall_cnt;
        cpu_exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) stall_cnt = 0;
            else if (cpu_req) begin
                if (cpu_stall) stall_cnt++;
                else if (cpu_q.size() == 0) begin
                    fail_now("unexpected cpu completion");
                    stall_cnt = 0;
                end else begin
                    e = cpu_q.pop_front();
                    chk("cpu_we", 32'(cpu_we), 32'(e.we));
                    if (!e.we) chk("cpu_rdata", cpu_rdata, e.rdata);
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                    stall_cnt = 0;
                end
            end
        end
    end

    // Memory-side monitor: every accepted request must match the expected sequence.
    initial begin
        mem_exp_t m;
        forever begin
            @(negedge clk);
            if (rst && mem_req && mem_ready) begin
                if (mem_q.size() == 0) fail_now("unexpected mem request");
                else begin
                    m = mem_q.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    chk("mem_addr", mem_addr, m.addr);
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        forever begin
            @(negedge clk);
            if (!cpu_stall) break;
            n++;
            if (n > 200) begin
                fail_now("access timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input int stalls, input bit fills);
        cpu_exp_t c;
        mem_exp_t m;
        c.we = 1'b0; c.rdata = exp; c.stalls = stalls;
        cpu_q.push_back(c);
        if (fills) begin
            for (int i = 0; i < 4; i++) begin
                m.we = 1'b0; m.addr = (addr & ~32'hF) + 32'(4 * i); m.wdata = '0;
                mem_q.push_back(m);
            end
        end
        access(1'b0, addr, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input int stalls);
        cpu_exp_t c;
        mem_exp_t m;
        c.we = 1'b1; c.rdata = '0; c.stalls = stalls;
        cpu_q.push_back(c);
        m.we = 1'b1; m.addr = addr & ~32'h3; m.wdata = data;
        mem_q.push_back(m);
        access(1'b1, addr, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_exp_t m;
        int n;
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset cpu_stall", 32'(cpu_stall), 32'h0);
        chk("reset mem_req", 32'(mem_req), 32'h0);
        chk("reset cpu_rdata", cpu_rdata, 32'h0);
        @(posedge clk);
        #1;

        rd(32'h100, 32'hA0, 9, 1);
        rd(32'h104, 32'hA1, 0, 0);
        wr(32'h108, 32'hDEADBEEF, 2);
        rd(32'h108, 32'hDEADBEEF, 0, 0);

        ready_delay = 2; wait_left = 2;
        wr(32'h2000, 32'h12345678, 4);
        ready_delay = 0; wait_left = 0;
        rd(32'h2000, 32'h12345678, 9, 1);

        rd(32'h100, 32'hA0, 9, 1);
        rd(32'h200, 32'hE0, 9, 1);
        rd(32'h100, 32'hA0, 9, 1);
        rd(32'h108, 32'hDEADBEEF, 0, 0);
        rd(32'h310, 32'h124, 9, 1);

        fork
            rd(32'h424, 32'h169, 9, 1);
            begin
                repeat (3) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        rd(32'h100, 32'hA0, 25, 1);
        rd(32'h314, 32'h125, 9, 1);

        // Reset in the middle of a fill, with a late response and stale pulses afterwards.
        rd_lat = 20;
        m.we = 1'b0; m.addr = 32'h500; m.wdata = '0;
        mem_q.push_back(m);
        cpu_we = 1'b0; cpu_addr = 32'h500; cpu_req = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_req && mem_ready) break;
            n++;
            if (n > 50) begin
                fail_now("fill request timeout");
                break;
            end
        end
        @(posedge clk);
        #1 rst = 1'b0; cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; stale_n = 3;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("post-reset mem_req", 32'(mem_req), 32'h0);
            chk("post-reset cpu_stall", 32'(cpu_stall), 32'h0);
        end
        @(posedge clk);
        #1 rd_lat = 1;
        rd(32'h500, 32'h1A0, 9, 1);
        rd(32'h100, 32'hA0, 9, 1);

        repeat (5) @(posedge clk);
        chk("cpu queue drained", 32'(cpu_q.size()), 32'h0);
        chk("mem queue drained", 32'(mem_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache placed between the pipelined core's memory stage and the data memory. It replaces the single-cycle direct connection with a parametrised storage array and a miss/refill FSM. Hits return data combinationally with no stall. Misses, writes and flushes stall the pipeline while a one-outstanding-request handshake runs against backing memory.

## Interface
- `DATA_WIDTH`, 32, word width; fixed at 32 in this design.
- `ADDRESS_WIDTH`, 32, byte address width.
- `SETS`, 16, number of lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4, words per line; power of two, ≥2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: access request; held stable until a cycle with `cpu_stall`=0.
- `cpu_we` in 1: 1 = word store, 0 = load.
- `cpu_addr` in ADDRESS_WIDTH: byte address; bits [1:0] ignored.
- `cpu_wdata` in DATA_WIDTH: store data.
- `cpu_rdata` out DATA_WIDTH: load data, valid when `cpu_req & !cpu_we & !cpu_stall`.
- `cpu_stall` out 1: freeze the pipeline (combinational).
- `flush` in 1: single-cycle pulse; invalidate all lines.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDRESS_WIDTH: word-aligned memory address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_ready` in 1: request accepted this cycle when `mem_req`=1.
- `mem_rvalid` in 1: read data valid; arrives at least 1 cycle after acceptance.
- `mem_rdata` in DATA_WIDTH: read data.

## Operation
- Address split: [1:0] byte, then log2(WORDS_PER_LINE) word offset, then log2(SETS) index; remaining upper bits are the tag.
- Storage: per set, one valid bit, one tag and WORDS_PER_LINE data words.
- FSM states: IDLE, FILL_REQ, FILL_WAIT, WR_REQ, DONE, FLUSH.
- **IDLE, no request.** `cpu_stall`=0.
- **IDLE, read hit** (valid and tag match). `cpu_rdata` is the indexed word; `cpu_stall`=0; stay in IDLE.
- **IDLE, read miss.** `cpu_stall`=1. Clear the fill counter. Go to FILL_REQ.
- **IDLE, write.** Hit or miss, `cpu_stall`=1. Go to WR_REQ.
- **IDLE, `flush`=1.** Takes priority over `cpu_req`. Go to FLUSH.
- **FILL_REQ.** `mem_req`=1, `mem_we`=0, `mem_addr`={tag, index, counter, 2'b00}. On `mem_ready`, go to FILL_WAIT.
- **FILL_WAIT.** On `mem_rvalid`, write `mem_rdata` into word[counter] and increment the counter. If that was the last word, set valid, write the tag and go to DONE; otherwise return to FILL_REQ.
  - The valid bit stays clear during the fill.
  - `mem_rvalid` in any other state is ignored.
- **WR_REQ.** `mem_req`=1, `mem_we`=1, `mem_addr`=cpu_addr word-aligned, `mem_wdata`=cpu_wdata. In the `mem_ready` cycle, if the line hits, the cached word is updated. Then go to DONE. A write miss never allocates.
- **DONE.** `cpu_stall`=0 and the held request completes; a load reads the array, which is now guaranteed to hit. Next state is FLUSH if a flush is pending, otherwise IDLE.
- **FLUSH.** Clear the valid bit of one set per cycle, index 0 to SETS-1, with `cpu_stall`=1. Then go to IDLE.
- A `flush` pulse arriving in any state other than IDLE is latched as pending and serviced after DONE.
- `cpu_stall`=1 in every state except IDLE-hit/idle and DONE.
- `mem_req`=0 outside FILL_REQ and WR_REQ.
- Reset values: all valid bits 0, state IDLE, counter 0, flush-pending 0, `mem_req`=0, `cpu_stall`=0 (absent request), `cpu_rdata` 0.
- Reset mid-fill: the partially filled line stays invalid. Any late `mem_rvalid` after reset is ignored.

## Timing
- Read hit: 0 stall cycles.
- Read miss, with memory ready immediately and rvalid 1 cycle later: stall for 2·WORDS_PER_LINE+1 cycles; DONE follows. With defaults, requests in C0 see stall in C0–C8 and data in C9.
- Write: stall for 2 cycles plus any `mem_ready` wait cycles; DONE follows.
- Flush: SETS cycles of stall.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_count` and `miss_count`, each 32-bit, reset to 0.
  - Increment once per completed load: hit if it completed without stall, miss on DONE following a fill.
  - Counters saturate at all-ones.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- `dcache_pkg` holds:
  - the state enum;
  - `localparam`-derived field widths (OFFSET_W, INDEX_W, TAG_W) as functions of the parameters;
  - the address-split struct.
- One sub-module, `dcache_array`: valid/tag/data storage.
  - Async-reset valid bits, combinational read port.
  - One word-write port, one line-validate port, one single-set invalidate port.

## Test plan
- After reset, read of 0x100 with memory returning 0xA0+n for word n: 9 stall cycles, `cpu_rdata`=0xA0. A repeat read of 0x104 returns 0xA1 with no stall.
- Write 0xDEADBEEF to 0x108 (a hit): one memory write to 0x108. A subsequent read of 0x108 returns 0xDEADBEEF with no stall.
- Write to 0x2000 (a miss): one memory write and no fill. A following read of 0x2000 misses.
- Conflict: read 0x100, then 0x100+SETS·16 (same index, different tag), then 0x100 again: each read refills.
- `flush` pulse during a fill: the fill completes and DONE returns data, then FLUSH runs for 16 cycles. Reads to previously cached lines then miss.
- `rst` asserted in FILL_WAIT with stale `mem_rvalid` pulses after release: no line becomes valid and `mem_req`=0 until the next request.
